g_or_reduce: RTL and testbench



---
 rtl/g_or_reduce.sv | 117 +++++++++++
 tb/tb_g_or_reduce.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g_or_reduce.sv
// Pipelined FANIN-ary OR/NOR reduction tree, one register stage per level.
// Define G_OR_REDUCE_STICKY_EN to add the clearable sticky "any result" flag.
module g_or_reduce #(
    parameter int WIDTH = 16,
    parameter int FANIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             invert,
`ifdef G_OR_REDUCE_STICKY_EN
    input  logic             clear,
    output logic             sticky,
`endif
    output logic             out_valid,
    output logic             out
);

    function automatic int calc_levels(input int w, input int f);
        int lv;
        int cap;
        lv  = 1;
        cap = f;
        while (cap < w) begin
            cap = cap * f;
            lv  = lv + 1;
        end
        return lv;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, FANIN);
    localparam int NW     = (WIDTH + FANIN - 1) / FANIN;
    localparam int PW     = NW * FANIN;

    logic [NW-1:0]    data_q [LEVELS];
    logic [NW-1:0]    data_d [LEVELS];
    logic [WIDTH-1:0] lvl_in [LEVELS];
    logic             vld_in [LEVELS];
    logic             inv_in [LEVELS];
    logic             valid_q [LEVELS];
    logic             inv_q  [LEVELS];
    logic [PW-1:0]    pad;
    logic             out_q;
    logic             result_d;
    logic             final_load;

    always_comb begin
        lvl_in[0] = in_data;
        vld_in[0] = in_valid;
        inv_in[0] = invert;
        for (int l = 1; l < LEVELS; l++) begin
            lvl_in[l] = WIDTH'(data_q[l-1]);
            vld_in[l] = valid_q[l-1];
            inv_in[l] = inv_q[l-1];
        end
    end

    // Upper node slots are zero-padded, the OR identity
    always_comb begin
        pad = '0;
        for (int l = 0; l < LEVELS; l++) begin
            pad = PW'(lvl_in[l]);
            for (int i = 0; i < NW; i++) begin
                data_d[l][i] = |pad[i*FANIN +: FANIN];
            end
        end
    end

    assign result_d   = data_d[LEVELS-1][0] ^ inv_in[LEVELS-1];
    assign final_load = en & vld_in[LEVELS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LEVELS; l++) begin
                valid_q[l] <= 1'b0;
                inv_q[l]   <= 1'b0;
                data_q[l]  <= '0;
            end
            out_q <= 1'b0;
        end else if (en) begin
            for (int l = 0; l < LEVELS; l++) begin
                valid_q[l] <= vld_in[l];
                inv_q[l]   <= inv_in[l];
                if (vld_in[l]) begin
                    data_q[l] <= data_d[l];
                end
            end
            if (vld_in[LEVELS-1]) begin
                out_q <= result_d;
            end
        end
    end

`ifdef G_OR_REDUCE_STICKY_EN
    logic sticky_q;

    // Clear acts even while stalled; a coincident result wins over clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= (clear ? 1'b0 : sticky_q) | (final_load & result_d);
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_load;
    assign unused_load = final_load;
`endif

    assign out_valid = valid_q[LEVELS-1];
    assign out       = out_q;

endmodule

// File: tb/tb_g_or_reduce.sv
// Directed bench for g_or_reduce: 16/4 (LEVELS=2) and 17/4 (LEVELS=3) instances.
// Sticky checks compile in when G_OR_REDUCE_STICKY_EN is defined.
module tb_g_or_reduce;

    logic        clk;
    logic        reset;
    logic        en;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_inv;
    logic        a_ov;
    logic        a_out;
    logic        b_valid;
    logic [16:0] b_data;
    logic        b_inv;
    logic        b_ov;
    logic        b_out;
    logic        a_clear;
    logic        b_clear;
    logic        a_sticky;
    logic        b_sticky;

    int tests;
    int fails;

    g_or_reduce #(.WIDTH(16), .FANIN(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (a_valid),
        .in_data   (a_data),
        .invert    (a_inv),
`ifdef G_OR_REDUCE_STICKY_EN
        .clear     (a_clear),
        .sticky    (a_sticky),
`endif
        .out_valid (a_ov),
        .out       (a_out)
    );

    g_or_reduce #(.WIDTH(17), .FANIN(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (b_valid),
        .in_data   (b_data),
        .invert    (b_inv),
`ifdef G_OR_REDUCE_STICKY_EN
        .clear     (b_clear),
        .sticky    (b_sticky),
`endif
        .out_valid (b_ov),
        .out       (b_out)
    );

`ifndef G_OR_REDUCE_STICKY_EN
    assign a_sticky = 1'b0;
    assign b_sticky = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset   = 1'b1;
        en      = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        a_inv   = 1'b0;
        b_valid = 1'b0;
        b_data  = '0;
        b_inv   = 1'b0;
        a_clear = 1'b0;
        b_clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({a_ov, a_out, a_sticky, b_ov, b_out} !== 5'b0) begin
                fails++;
                $display("FAIL reset_idle[%0d]: got ov=%b out=%b sticky=%b b_ov=%b b_out=%b, want all 0",
                         i, a_ov, a_out, a_sticky, b_ov, b_out);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 16'h0000;
        a_inv   = 1'b0;
        @(negedge clk);
        tests++;
        if (a_ov !== 1'b0) begin
            fails++;
            $display("FAIL lat_early: got ov=%b, want 0", a_ov);
        end
        a_data = 16'h0100;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b10) begin
            fails++;
            $display("FAIL lat_beat0: got ov=%b out=%b, want ov=1 out=0", a_ov, a_out);
        end
        a_data = 16'hFFFF;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b11) begin
            fails++;
            $display("FAIL lat_beat1: got ov=%b out=%b, want ov=1 out=1", a_ov, a_out);
        end
        a_valid = 1'b0;
        a_data  = 16'h0000;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b11) begin
            fails++;
            $display("FAIL lat_beat2: got ov=%b out=%b, want ov=1 out=1", a_ov, a_out);
        end
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b01) begin
            fails++;
            $display("FAIL lat_hold: got ov=%b out=%b, want ov=0 out=1", a_ov, a_out);
        end
    endtask

    task automatic test_nor();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 16'h0000;
        a_inv   = 1'b1;
        @(negedge clk);
        tests++;
        if (a_ov !== 1'b0) begin
            fails++;
            $display("FAIL nor_early: got ov=%b, want 0", a_ov);
        end
        a_data = 16'h8000;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b11) begin
            fails++;
            $display("FAIL nor_zero: got ov=%b out=%b, want ov=1 out=1", a_ov, a_out);
        end
        a_valid = 1'b0;
        a_inv   = 1'b0;
        a_data  = 16'h0000;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b10) begin
            fails++;
            $display("FAIL nor_msb: got ov=%b out=%b, want ov=1 out=0", a_ov, a_out);
        end
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b00) begin
            fails++;
            $display("FAIL nor_hold: got ov=%b out=%b, want ov=0 out=0", a_ov, a_out);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 16'h0001;
        a_inv   = 1'b0;
        @(negedge clk);
        tests++;
        if (a_ov !== 1'b0) begin
            fails++;
            $display("FAIL stall_early: got ov=%b, want 0", a_ov);
        end
        a_valid = 1'b0;
        a_data  = 16'h0000;
        en      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (a_ov !== 1'b0) begin
                fails++;
                $display("FAIL stall_quiet[%0d]: got ov=%b, want 0", i, a_ov);
            end
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b11) begin
            fails++;
            $display("FAIL stall_out: got ov=%b out=%b, want ov=1 out=1", a_ov, a_out);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({a_ov, a_out} !== 2'b11) begin
                fails++;
                $display("FAIL stall_held[%0d]: got ov=%b out=%b, want ov=1 out=1", i, a_ov, a_out);
            end
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if ({a_ov, a_out} !== 2'b01) begin
            fails++;
            $display("FAIL stall_release: got ov=%b out=%b, want ov=0 out=1", a_ov, a_out);
        end
    endtask

    task automatic test_odd_width();
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 17'h10000;
        b_inv   = 1'b0;
        @(negedge clk);
        tests++;
        if (b_ov !== 1'b0) begin
            fails++;
            $display("FAIL odd_e1: got ov=%b, want 0", b_ov);
        end
        b_data = 17'h00000;
        @(negedge clk);
        tests++;
        if (b_ov !== 1'b0) begin
            fails++;
            $display("FAIL odd_e2: got ov=%b, want 0", b_ov);
        end
        b_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({b_ov, b_out} !== 2'b11) begin
            fails++;
            $display("FAIL odd_pad_bit: got ov=%b out=%b, want ov=1 out=1", b_ov, b_out);
        end
        @(negedge clk);
        tests++;
        if ({b_ov, b_out} !== 2'b10) begin
            fails++;
            $display("FAIL odd_zero: got ov=%b out=%b, want ov=1 out=0", b_ov, b_out);
        end
        @(negedge clk);
        tests++;
        if ({b_ov, b_out} !== 2'b00) begin
            fails++;
            $display("FAIL odd_hold: got ov=%b out=%b, want ov=0 out=0", b_ov, b_out);
        end
    endtask

    task automatic test_reset_flight();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 16'hFFFF;
        b_valid = 1'b1;
        b_data  = 17'h1FFFF;
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({a_ov, a_out, a_sticky, b_ov} !== 4'b0) begin
                fails++;
                $display("FAIL flight_drop[%0d]: got ov=%b out=%b sticky=%b b_ov=%b, want all 0",
                         i, a_ov, a_out, a_sticky, b_ov);
            end
            @(negedge clk);
        end
    endtask

`ifdef G_OR_REDUCE_STICKY_EN
    task automatic test_sticky();
        @(negedge clk);
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        tests++;
        if (a_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_init: got %b, want 0", a_sticky);
        end
        a_valid = 1'b1;
        a_data  = 16'h0000;
        a_inv   = 1'b0;
        @(negedge clk);
        a_data = 16'h0004;
        @(negedge clk);
        a_data = 16'h0000;
        tests++;
        if (a_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_r0: got %b, want 0", a_sticky);
        end
        @(negedge clk);
        a_valid = 1'b0;
        tests++;
        if (a_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_r1: got %b, want 1", a_sticky);
        end
        @(negedge clk);
        tests++;
        if (a_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_r2: got %b, want 1", a_sticky);
        end
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        tests++;
        if (a_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clear: got %b, want 0", a_sticky);
        end
        a_valid = 1'b1;
        a_data  = 16'h0004;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 16'h0000;
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        tests++;
        if ({a_ov, a_sticky} !== 2'b11) begin
            fails++;
            $display("FAIL sticky_clr_set: got ov=%b sticky=%b, want ov=1 sticky=1", a_ov, a_sticky);
        end
        en      = 1'b0;
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        en      = 1'b1;
        tests++;
        if (a_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clr_stall: got %b, want 0", a_sticky);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_nor();
        test_stall();
        test_odd_width();
`ifdef G_OR_REDUCE_STICKY_EN
        test_sticky();
`endif
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
